// File: rtl/operand_issue_stage.sv
// Operand issue stage: 8-entry register file, per-register pending scoreboard and a
// one-deep registered output slot feeding functionalUnit. Optional macro WB_FORWARD_EN.
module operand_issue_stage #(
    parameter int DATA_W = 15,
    parameter int REG_N  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fs,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic [ADDR_W-1:0] in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] inS,
    output logic [DATA_W-1:0] inT,
    output logic [2:0]        functionSelect,
    output logic [ADDR_W-1:0] out_rd,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    logic [DATA_W-1:0] regFile [REG_N];
    logic [REG_N-1:0]  pending;
    logic [REG_N-1:0]  pendingNext;

    logic              hazardS;
    logic              hazardT;
    logic              hazardD;
    logic              hazard;
    logic              slotFree;
    logic              accept;
    logic [DATA_W-1:0] operandS;
    logic [DATA_W-1:0] operandT;

`ifdef WB_FORWARD_EN
    logic wbHitS;
    logic wbHitT;
    logic wbHitD;

    // A write-back landing this cycle both resolves the dependency and supplies the value.
    always_comb begin
        wbHitS   = wb_en && (wb_addr == in_rs) && (in_rs != '0);
        wbHitT   = wb_en && (wb_addr == in_rt) && (in_rt != '0);
        wbHitD   = wb_en && (wb_addr == in_rd) && (in_rd != '0);
        hazardS  = pending[in_rs] && (in_rs != '0) && !wbHitS;
        hazardT  = pending[in_rt] && (in_rt != '0) && !wbHitT;
        hazardD  = pending[in_rd] && (in_rd != '0) && !wbHitD;
        operandS = wbHitS ? wb_data : regFile[in_rs];
        operandT = wbHitT ? wb_data : regFile[in_rt];
    end
`else
    always_comb begin
        hazardS  = pending[in_rs] && (in_rs != '0);
        hazardT  = pending[in_rt] && (in_rt != '0);
        hazardD  = pending[in_rd] && (in_rd != '0);
        operandS = regFile[in_rs];
        operandT = regFile[in_rt];
    end
`endif

    always_comb begin
        hazard   = hazardS || hazardT || hazardD;
        slotFree = !out_valid || out_ready;
        in_ready = slotFree && !hazard;
        accept   = in_valid && in_ready;
    end

    // A newly accepted writer is younger than any write-back in flight, so its set wins.
    always_comb begin
        pendingNext = pending;
        if (wb_en) begin
            pendingNext[wb_addr] = 1'b0;
        end
        if (accept && (in_rd != '0)) begin
            pendingNext[in_rd] = 1'b1;
        end
        pendingNext[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pendingNext;
        end
    end

    // R0 is never written, so its reset value of zero is permanent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) begin
                regFile[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            regFile[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            inS            <= '0;
            inT            <= '0;
            functionSelect <= '0;
            out_rd         <= '0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            inS            <= operandS;
            inT            <= operandT;
            functionSelect <= in_fs;
            out_rd         <= in_rd;
        end else if (out_ready) begin
            out_valid      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_issue_stage.sv
// Scoreboard bench for operand_issue_stage: directed scenarios followed by random traffic,
// checked against an array/queue reference model. Honours WB_FORWARD_EN like the design.
module tb_operand_issue_stage;

    localparam int DW = 15;
    localparam int AW = 3;

    typedef struct packed {
        logic [DW-1:0] s;
        logic [DW-1:0] t;
        logic [2:0]    fs;
        logic [AW-1:0] rd;
    } bundle_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_fs;
    logic [AW-1:0] in_rs;
    logic [AW-1:0] in_rt;
    logic [AW-1:0] in_rd;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] inS;
    logic [DW-1:0] inT;
    logic [2:0]    functionSelect;
    logic [AW-1:0] out_rd;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;

    operand_issue_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_fs(in_fs),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .inS(inS), .inT(inT), .functionSelect(functionSelect), .out_rd(out_rd),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    bit inReset = 1'b1;

    logic [DW-1:0] rfM [8];
    bit            pendM [8];
    bundle_t       q [$];
    bit            slotFree;
    bit            expReady;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit blocked(logic [AW-1:0] a);
        if (a == 0 || !pendM[a]) return 1'b0;
`ifdef WB_FORWARD_EN
        if (wb_en && wb_addr == a) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [DW-1:0] readM(logic [AW-1:0] a);
`ifdef WB_FORWARD_EN
        if (a != 0 && wb_en && wb_addr == a) return wb_data;
`endif
        return rfM[a];
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 8; i++) begin
            rfM[i] = '0;
            pendM[i] = 1'b0;
        end
        q.delete();
    endtask

    // Reference model: judges the handshake just before each rising edge.
    always @(negedge clk) begin
        if (!inReset) begin
            slotFree = (q.size() == 0) || out_ready;
            expReady = slotFree && !(blocked(in_rs) || blocked(in_rt) || blocked(in_rd));
            chk("in_ready", in_ready, expReady);
            if (in_valid && expReady)
                q.push_back('{s: readM(in_rs), t: readM(in_rt), fs: in_fs, rd: in_rd});
            if (wb_en && wb_addr != 0) begin
                rfM[wb_addr] = wb_data;
                pendM[wb_addr] = 1'b0;
            end
            if (in_valid && expReady && in_rd != 0)
                pendM[in_rd] = 1'b1;
        end
    end

    // Monitor: the head of the queue must be presented, unchanged, until consumed.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (!inReset) begin
                chk("out_valid", out_valid, q.size() != 0);
                if (q.size() != 0) begin
                    chk("bundle", {inS, inT, functionSelect, out_rd}, q[0]);
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    task automatic step(bit v, logic [2:0] fs, logic [AW-1:0] rs, logic [AW-1:0] rt,
                        logic [AW-1:0] rd, bit ordy, bit we, logic [AW-1:0] wa,
                        logic [DW-1:0] wd);
        in_valid = v; in_fs = fs; in_rs = rs; in_rt = rt; in_rd = rd;
        out_ready = ordy; wb_en = we; wb_addr = wa; wb_data = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic quiesce();
        for (int a = 1; a < 8; a++)
            step(0, 0, 0, 0, 0, 1, 1, AW'(a), DW'($urandom));
    endtask

    initial begin
        clearModel();
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset inS", inS, 0);
        chk("reset inT", inT, 0);
        chk("reset functionSelect", functionSelect, 0);
        chk("reset out_rd", out_rd, 0);
        rst_n = 1'b1;
        inReset = 1'b0;

        // Basic issue with a negative operand.
        step(0, 0, 0, 0, 0, 1, 1, 1, 15'h7FFB);
        step(0, 0, 0, 0, 0, 1, 1, 2, 15'h000C);
        step(1, 0, 1, 2, 3, 1, 0, 0, 0);
        // RAW on R3, resolved by a write-back.
        step(1, 1, 3, 0, 0, 1, 0, 0, 0);
        step(1, 1, 3, 0, 5, 1, 1, 3, 15'd7);
        step(1, 1, 3, 0, 5, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        quiesce();

        // Downstream back-pressure, then back-to-back on release.
        step(1, 2, 1, 2, 6, 0, 0, 0, 0);
        repeat (3) step(1, 3, 1, 2, 7, 0, 0, 0, 0);
        step(1, 3, 1, 2, 7, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        quiesce();

        // R0 semantics.
        step(1, 3, 0, 0, 0, 1, 1, 0, 15'h1234);
        step(1, 4, 0, 0, 0, 1, 0, 0, 0);
        step(1, 4, 1, 0, 1, 1, 0, 0, 0);
        quiesce();

        // Accept rd=4 together with a write-back to R4: R4 must stay pending.
        step(1, 5, 1, 2, 4, 1, 1, 4, 15'h0055);
        step(1, 5, 4, 0, 0, 1, 0, 0, 0);
        step(1, 5, 0, 4, 0, 1, 0, 0, 0);
        quiesce();
        step(1, 5, 4, 4, 0, 1, 0, 0, 0);
        quiesce();

        // Asynchronous reset with a held bundle and a pending R6.
        step(1, 6, 1, 2, 6, 1, 0, 0, 0);
        in_valid = 1'b0;
        out_ready = 1'b0;
        inReset = 1'b1;
        #3;
        chk("pre-reset out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", out_valid, 0);
        chk("async reset bundle", {inS, inT, functionSelect, out_rd}, 0);
        clearModel();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        inReset = 1'b0;
        step(1, 7, 6, 6, 6, 1, 0, 0, 0);
        step(1, 7, 6, 1, 0, 1, 0, 0, 0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 4) != 0, 3'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
                 ($urandom % 10) < 7, $urandom % 2, AW'($urandom), DW'($urandom));
        end

        repeat (4) step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
